// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI slave link: FSM states, frame widths, fill patterns.
package spi_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OOB  = 2'd1,
    WORD = 2'd2
  } link_state_e;

  localparam int          BYTE_BITS         = 8;
  localparam int          WORD_BITS         = 32;
  localparam logic [31:0] DEF_UNDERRUN_WORD = 32'hDEAD_BEEF;
  localparam logic [7:0]  DEF_OOB_IDLE_BYTE = 8'hA5;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the four SPI pins into clk and derives sclk/frame edge pulses one flop later.
// All outputs share the same SYNC_STAGES latency, so mosi and frame stay aligned with sclk edges.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_spi_clk,
  input  logic i_spi_mosi,
  input  logic i_spi_cs,
  input  logic i_spi_frame,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_mosi,
  output logic o_cs_n,
  output logic o_frame,
  output logic o_frame_rise,
  output logic o_frame_fall
);

  // Bit layout {frame, cs, mosi, sclk}; cs resets high so no spurious select is seen.
  localparam logic [3:0] SYNC_RST = 4'b0100;

  logic [3:0] r_sync [SYNC_STAGES];
  logic [1:0] r_prev;
  logic [3:0] w_pins;

  assign w_pins = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
      r_prev <= 2'b00;
    end else begin
      r_sync[0] <= {i_spi_frame, i_spi_cs, i_spi_mosi, i_spi_clk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= {w_pins[3], w_pins[0]};
    end
  end

  assign o_sclk_rise  =  w_pins[0] & ~r_prev[0];
  assign o_sclk_fall  = ~w_pins[0] &  r_prev[0];
  assign o_mosi       =  w_pins[1];
  assign o_cs_n       =  w_pins[2];
  assign o_frame      =  w_pins[3];
  assign o_frame_rise =  w_pins[3] & ~r_prev[1];
  assign o_frame_fall = ~w_pins[3] &  r_prev[1];

endmodule

// File: rtl/spi_slave_link.sv
// SPI slave: 32-bit words while frame is low, raw OOB bytes while frame is high, LSB first.
// SPI_SLAVE_LINK_STATS_EN adds saturating stat_underrun/stat_words/stat_oob counters.
module spi_slave_link
  import spi_link_pkg::*;
#(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] UNDERRUN_WORD = DEF_UNDERRUN_WORD,
  parameter logic [7:0]  OOB_IDLE_BYTE = DEF_OOB_IDLE_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  oob_rx_data,
  output logic        oob_rx_valid,
  input  logic [7:0]  oob_tx_data,
  input  logic        oob_tx_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        proto_err
`ifdef SPI_SLAVE_LINK_STATS_EN
  ,
  output logic [15:0] stat_underrun,
  output logic [15:0] stat_words,
  output logic [15:0] stat_oob
`endif
);

  logic w_sclk_rise, w_sclk_fall, w_mosi, w_cs_n, w_frame, w_frame_rise, w_frame_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk          (clk),
    .rst          (rst),
    .i_spi_clk    (spi_clk),
    .i_spi_mosi   (spi_mosi),
    .i_spi_cs     (spi_cs),
    .i_spi_frame  (spi_frame),
    .o_sclk_rise  (w_sclk_rise),
    .o_sclk_fall  (w_sclk_fall),
    .o_mosi       (w_mosi),
    .o_cs_n       (w_cs_n),
    .o_frame      (w_frame),
    .o_frame_rise (w_frame_rise),
    .o_frame_fall (w_frame_fall)
  );

  link_state_e r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rx, r_tx, r_rx_data;
  logic [7:0]  r_oob_rx_data;
  logic        r_rx_valid, r_oob_rx_valid, r_tx_ready, r_frame_start, r_frame_end, r_proto_err;

  logic        w_active, w_done, w_to_idle, w_to_oob, w_to_word, w_leave, w_abort;
  logic        w_load_word, w_load_oob;
  logic [4:0]  w_last;
  logic [31:0] w_word_load, w_rx_word;
  logic [7:0]  w_oob_load, w_rx_byte;

  assign w_active    = (r_state != IDLE);
  assign w_last      = (r_state == WORD) ? 5'(WORD_BITS - 1) : 5'(BYTE_BITS - 1);
  assign w_done      = w_active && w_sclk_rise && (r_cnt == w_last);
  assign w_to_idle   = w_active && w_cs_n;
  assign w_to_oob    = !w_cs_n && ((r_state == IDLE && w_frame) || (r_state == WORD && w_frame_rise));
  assign w_to_word   = !w_cs_n && ((r_state == IDLE && !w_frame) || (r_state == OOB && w_frame_fall));
  assign w_leave     = w_to_idle || w_to_oob || w_to_word;
  // A final rising edge coinciding with a mode change still completes cleanly.
  assign w_abort     = w_leave && w_active && (r_cnt != 5'd0) && !w_done;
  assign w_load_word = w_to_word || (w_done && !w_leave && r_state == WORD);
  assign w_load_oob  = w_to_oob || (w_done && !w_leave && r_state == OOB);
  assign w_word_load = tx_valid ? tx_data : UNDERRUN_WORD;
  assign w_oob_load  = oob_tx_valid ? oob_tx_data : OOB_IDLE_BYTE;
  assign w_rx_word   = {w_mosi, r_rx[31:1]};
  assign w_rx_byte   = {w_mosi, r_rx[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_rx           <= '0;
      r_tx           <= '0;
      r_rx_data      <= '0;
      r_oob_rx_data  <= '0;
      r_rx_valid     <= 1'b0;
      r_oob_rx_valid <= 1'b0;
      r_tx_ready     <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_end    <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      r_rx_valid     <= 1'b0;
      r_oob_rx_valid <= 1'b0;
      r_tx_ready     <= 1'b0;
      r_frame_start  <= w_frame_fall && !w_cs_n;
      r_frame_end    <= w_frame_rise;
      if (w_active && w_sclk_rise) begin
        r_cnt <= w_done ? 5'd0 : r_cnt + 5'd1;
        if (r_state == WORD) r_rx <= w_rx_word;
        else                 r_rx <= {r_rx[31:8], w_rx_byte};
      end
      // Bit 0 goes out at the boundary; the falling edge after the last bit must not shift it away.
      if (w_active && w_sclk_fall && r_cnt != 5'd0) r_tx <= {1'b0, r_tx[31:1]};
      if (w_done && r_state == WORD) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end
      if (w_done && r_state == OOB) begin
        r_oob_rx_data  <= w_rx_byte;
        r_oob_rx_valid <= 1'b1;
      end
      if (w_abort) r_proto_err <= 1'b1;
      if (w_leave) r_cnt <= '0;
      if (w_load_word) begin
        r_tx       <= w_word_load;
        r_tx_ready <= tx_valid;
      end
      if (w_load_oob) r_tx <= {24'd0, w_oob_load};
      if (w_to_idle) begin
        r_tx    <= '0;
        r_state <= IDLE;
      end else if (w_to_oob) begin
        r_state <= OOB;
      end else if (w_to_word) begin
        r_state <= WORD;
      end
    end
  end

  assign spi_miso     = r_tx[0];
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign tx_ready     = r_tx_ready;
  assign oob_rx_data  = r_oob_rx_data;
  assign oob_rx_valid = r_oob_rx_valid;
  assign frame_start  = r_frame_start;
  assign frame_end    = r_frame_end;
  assign proto_err    = r_proto_err;

`ifdef SPI_SLAVE_LINK_STATS_EN
  logic [15:0] r_stat_underrun, r_stat_words, r_stat_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_underrun <= '0;
      r_stat_words    <= '0;
      r_stat_oob      <= '0;
    end else begin
      if (w_load_word && !tx_valid && r_stat_underrun != 16'hFFFF) r_stat_underrun <= r_stat_underrun + 16'd1;
      if (w_done && r_state == WORD && r_stat_words != 16'hFFFF) r_stat_words <= r_stat_words + 16'd1;
      if (w_done && r_state == OOB && r_stat_oob != 16'hFFFF) r_stat_oob <= r_stat_oob + 16'd1;
    end
  end

  assign stat_underrun = r_stat_underrun;
  assign stat_words    = r_stat_words;
  assign stat_oob      = r_stat_oob;
`endif

endmodule

// File: tb/tb_spi_slave_link.sv
// Directed bench for spi_slave_link: the bench acts as SPI master and as the downstream tx/rx side.
module tb_spi_slave_link;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_frame = 1'b0;
  logic        spi_miso;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  oob_rx_data;
  logic        oob_rx_valid;
  logic [7:0]  oob_tx_data = '0;
  logic        oob_tx_valid = 1'b0;
  logic        frame_start, frame_end, proto_err;
`ifdef SPI_SLAVE_LINK_STATS_EN
  logic [15:0] stat_underrun, stat_words, stat_oob;
`endif

  spi_slave_link dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs       (spi_cs),
    .spi_frame    (spi_frame),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .oob_rx_data  (oob_rx_data),
    .oob_rx_valid (oob_rx_valid),
    .oob_tx_data  (oob_tx_data),
    .oob_tx_valid (oob_tx_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .proto_err    (proto_err)
`ifdef SPI_SLAVE_LINK_STATS_EN
    ,
    .stat_underrun (stat_underrun),
    .stat_words    (stat_words),
    .stat_oob      (stat_oob)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] rx_q [$];
  logic [7:0]  oob_q [$];
  int ready_cnt = 0, fstart_cnt = 0, fend_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid)     rx_q.push_back(rx_data);
    if (oob_rx_valid) oob_q.push_back(oob_rx_data);
    if (tx_ready)     ready_cnt++;
    if (frame_start)  fstart_cnt++;
    if (frame_end)    fend_cnt++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int k);
    return (k < rx_q.size()) ? rx_q[k] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] oob_at(input int k);
    return (k < oob_q.size()) ? {24'd0, oob_q[k]} : 32'hxxxx_xxxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input int n, input logic [31:0] d, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[i];
      wait_clk(HALF);
      got[i] = spi_miso;
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic sess_start(input logic frm);
    spi_frame = frm;
    wait_clk(2);
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic sess_end();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic frame_set(input logic frm);
    wait_clk(HALF);
    spi_frame = frm;
    wait_clk(HALF);
  endtask

  typedef struct {
    logic        word;
    logic [31:0] mosi;
    logic [31:0] tx;
    logic        tx_vld;
    logic [31:0] exp_miso;
    logic [31:0] exp_rx;
    int          exp_rdy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] got;
    int rb, ob, rdy0, fs0, fe0;

    vecs[0] = '{1'b0, 32'h3C,        32'h5A,        1'b1, 32'h5A,        32'h3C,        0};
    vecs[1] = '{1'b0, 32'h81,        32'h00,        1'b0, 32'hA5,        32'h81,        0};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 32'h1234_5678, 1};
    vecs[3] = '{1'b1, 32'hCAFE_F00D, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 1};
    vecs[5] = '{1'b0, 32'h00,        32'hFF,        1'b1, 32'hFF,        32'h00,        0};

    // Reset state
    wait_clk(4);
    chk("reset miso", {31'd0, spi_miso}, 32'd0);
    chk("reset rx_data", rx_data, 32'd0);
    chk("reset oob_rx_data", {24'd0, oob_rx_data}, 32'd0);
    chk("reset pulses", {27'd0, rx_valid, oob_rx_valid, tx_ready, frame_start, frame_end}, 32'd0);
    chk("reset proto_err", {31'd0, proto_err}, 32'd0);
`ifdef SPI_SLAVE_LINK_STATS_EN
    chk("reset stats", {stat_underrun, stat_words | stat_oob}, 32'd0);
`endif
    rst = 1'b0;
    wait_clk(4);

    // Single-transfer sessions from the table
    for (int i = 0; i < 6; i++) begin
      rb = rx_q.size();
      ob = oob_q.size();
      rdy0 = ready_cnt;
      if (vecs[i].word) begin
        tx_data = vecs[i].tx;
        tx_valid = vecs[i].tx_vld;
      end else begin
        oob_tx_data = vecs[i].tx[7:0];
        oob_tx_valid = vecs[i].tx_vld;
      end
      sess_start(!vecs[i].word);
      tx_valid = 1'b0;
      oob_tx_valid = 1'b0;
      xfer(vecs[i].word ? 32 : 8, vecs[i].mosi, got);
      sess_end();
      chk($sformatf("vec%0d miso", i), got, vecs[i].exp_miso);
      if (vecs[i].word) begin
        chk($sformatf("vec%0d rx count", i), 32'(rx_q.size() - rb), 32'd1);
        chk($sformatf("vec%0d rx data", i), rx_at(rb), vecs[i].exp_rx);
      end else begin
        chk($sformatf("vec%0d oob count", i), 32'(oob_q.size() - ob), 32'd1);
        chk($sformatf("vec%0d oob data", i), oob_at(ob), vecs[i].exp_rx);
      end
      chk($sformatf("vec%0d tx_ready", i), 32'(ready_cnt - rdy0), 32'(vecs[i].exp_rdy));
    end
    chk("table proto_err", {31'd0, proto_err}, 32'd0);

    // OOB exchange: two bytes in one session, same reply byte held valid
    ob = oob_q.size();
    oob_tx_data = 8'h5A;
    oob_tx_valid = 1'b1;
    sess_start(1'b1);
    xfer(8, 32'h3C, got);
    chk("oobx miso0", got, 32'h5A);
    xfer(8, 32'h81, got);
    chk("oobx miso1", got, 32'h5A);
    sess_end();
    oob_tx_valid = 1'b0;
    chk("oobx count", 32'(oob_q.size() - ob), 32'd2);
    chk("oobx rx0", oob_at(ob), 32'h3C);
    chk("oobx rx1", oob_at(ob + 1), 32'h81);

    // Word frame inside an OOB session: frame_start/frame_end and two tx consumes
    rb = rx_q.size();
    tx_data = 32'h0BAD_F00D;
    tx_valid = 1'b1;
    sess_start(1'b1);
    rdy0 = ready_cnt;
    fs0 = fstart_cnt;
    fe0 = fend_cnt;
    frame_set(1'b0);
    xfer(32, 32'h1234_5678, got);
    chk("wf miso0", got, 32'h0BAD_F00D);
    tx_valid = 1'b0;
    xfer(32, 32'hCAFE_F00D, got);
    chk("wf miso1", got, 32'h0BAD_F00D);
    frame_set(1'b1);
    sess_end();
    chk("wf rx count", 32'(rx_q.size() - rb), 32'd2);
    chk("wf rx0", rx_at(rb), 32'h1234_5678);
    chk("wf rx1", rx_at(rb + 1), 32'hCAFE_F00D);
    chk("wf frame_start", 32'(fstart_cnt - fs0), 32'd1);
    chk("wf frame_end", 32'(fend_cnt - fe0), 32'd1);
    chk("wf tx_ready", 32'(ready_cnt - rdy0), 32'd2);
    chk("wf proto_err", {31'd0, proto_err}, 32'd0);

    // Abort: frame rises after 12 word bits, then an OOB byte follows
    rb = rx_q.size();
    ob = oob_q.size();
    oob_tx_data = 8'hC3;
    oob_tx_valid = 1'b1;
    sess_start(1'b0);
    xfer(12, 32'h0000_0ABC, got);
    frame_set(1'b1);
    chk("abort proto_err", {31'd0, proto_err}, 32'd1);
    xfer(8, 32'h77, got);
    sess_end();
    oob_tx_valid = 1'b0;
    chk("abort rx count", 32'(rx_q.size() - rb), 32'd0);
    chk("abort oob count", 32'(oob_q.size() - ob), 32'd1);
    chk("abort oob data", oob_at(ob), 32'h77);
    chk("abort oob miso", got, 32'hC3);

    // Reset in the middle of a word
    rb = rx_q.size();
    sess_start(1'b0);
    xfer(5, 32'h0000_001F, got);
    rst = 1'b1;
    wait_clk(2);
    chk("rstmid miso", {31'd0, spi_miso}, 32'd0);
    chk("rstmid proto_err", {31'd0, proto_err}, 32'd0);
    spi_cs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    sess_start(1'b0);
    xfer(32, 32'h0000_0001, got);
    sess_end();
    chk("rstmid miso word", got, 32'hDEAD_BEEF);
    chk("rstmid rx count", 32'(rx_q.size() - rb), 32'd1);
    chk("rstmid rx data", rx_at(rb), 32'h0000_0001);
    chk("rstmid proto_err after", {31'd0, proto_err}, 32'd0);

    // Three words (first one underruns) then two OOB bytes after a fresh reset
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    rb = rx_q.size();
    ob = oob_q.size();
    tx_data = 32'h55AA_55AA;
    tx_valid = 1'b0;
    sess_start(1'b0);
    tx_valid = 1'b1;
    xfer(32, 32'h0000_0011, got);
    chk("st miso0", got, 32'hDEAD_BEEF);
    xfer(32, 32'h0000_0022, got);
    chk("st miso1", got, 32'h55AA_55AA);
    xfer(32, 32'h0000_0033, got);
    chk("st miso2", got, 32'h55AA_55AA);
    frame_set(1'b1);
    tx_valid = 1'b0;
    xfer(8, 32'h10, got);
    chk("st oob miso0", got, 32'hA5);
    xfer(8, 32'h20, got);
    chk("st oob miso1", got, 32'hA5);
    sess_end();
    chk("st rx2", rx_at(rb + 2), 32'h0000_0033);
    chk("st oob1", oob_at(ob + 1), 32'h20);
`ifdef SPI_SLAVE_LINK_STATS_EN
    chk("stat_words", {16'd0, stat_words}, 32'd3);
    chk("stat_underrun", {16'd0, stat_underrun}, 32'd1);
    chk("stat_oob", {16'd0, stat_oob}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
